// File: rtl/fir_filter_tdm_if.sv
// Streaming and coefficient-port bundle for fir_filter_tdm.
// The slave modport is the filter's view; master is the source/sink/host side.
interface fir_filter_tdm_if #(
   parameter int N_TAPS    = 4,
   parameter int WW_INPUT  = 8,
   parameter int WW_COEFF  = 8,
   parameter int WW_OUTPUT = 8
);
   localparam int CNT_W = $clog2(N_TAPS);

   logic signed [WW_INPUT-1:0]  i_is_data;
   logic                        i_is_dv;
   logic                        o_is_rfd;
   logic signed [WW_OUTPUT-1:0] o_os_data;
   logic                        o_os_dv;
   logic                        i_os_rfd;
   logic                        i_coeff_wr;
   logic [CNT_W-1:0]            i_coeff_addr;
   logic signed [WW_COEFF-1:0]  i_coeff_data;

   modport master (
      output i_is_data, i_is_dv, i_os_rfd, i_coeff_wr, i_coeff_addr, i_coeff_data,
      input  o_is_rfd, o_os_data, o_os_dv
   );

   modport slave (
      input  i_is_data, i_is_dv, i_os_rfd, i_coeff_wr, i_coeff_addr, i_coeff_data,
      output o_is_rfd, o_os_data, o_os_dv
   );
endinterface

// File: rtl/fir_filter_tdm.sv
// Time-multiplexed FIR: one shared MAC walks N_TAPS taps per sample, dv/rfd on both sides.
// Optional round-half-up on the output is enabled by defining FIR_ROUND_EN.
module fir_filter_tdm #(
   parameter int N_TAPS    = 4,
   parameter int WW_INPUT  = 8,
   parameter int WW_COEFF  = 8,
   parameter int WW_OUTPUT = 8
) (
   input  logic              clk,
   input  logic              i_rst,
   input  logic              i_en,
   fir_filter_tdm_if.slave   bus
);
   localparam int PROD_W = WW_INPUT + WW_COEFF;
   localparam int CNT_W  = $clog2(N_TAPS);
   localparam int ACC_W  = PROD_W + CNT_W;
   localparam int RND_SH = (WW_OUTPUT < PROD_W) ? (PROD_W - 1 - WW_OUTPUT) : 0;
   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(N_TAPS - 1);
   localparam logic [CNT_W:0]   TAP_LIM  = (CNT_W + 1)'(N_TAPS);

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                      state;
   logic [CNT_W-1:0]            cnt;
   logic signed [ACC_W-1:0]     acc;
   logic signed [WW_INPUT-1:0]  taps   [N_TAPS];
   logic signed [WW_COEFF-1:0]  coeffs [N_TAPS];
   logic                        pend_wr;
   logic [CNT_W-1:0]            pend_addr;
   logic signed [WW_COEFF-1:0]  pend_data;
   logic signed [WW_OUTPUT-1:0] os_data;
   logic                        os_dv;
   logic                        is_rfd;

   logic signed [PROD_W-1:0]    prod;
   logic signed [ACC_W-1:0]     sum;
   logic                        addr_ok;

   function automatic logic signed [ACC_W-1:0] round_half(input logic signed [ACC_W-1:0] v);
`ifdef FIR_ROUND_EN
      if (WW_OUTPUT < PROD_W) return v + (ACC_W'(1) << RND_SH);
      else                    return v;
`else
      return v;
`endif
   endfunction

   // Bits above the output field must all match the sign, otherwise clamp.
   function automatic logic signed [WW_OUTPUT-1:0] saturate(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-PROD_W:0] hi;
      hi = v[ACC_W-1:PROD_W-1];
      if (hi == '0 || hi == '1) return v[PROD_W-1 -: WW_OUTPUT];
      else if (v[ACC_W-1])      return {1'b1, {(WW_OUTPUT-1){1'b0}}};
      else                      return {1'b0, {(WW_OUTPUT-1){1'b1}}};
   endfunction

   assign prod    = PROD_W'(coeffs[cnt]) * PROD_W'(taps[cnt]);
   assign sum     = acc + ACC_W'(prod);
   assign addr_ok = {1'b0, bus.i_coeff_addr} < TAP_LIM;

   assign bus.o_is_rfd  = is_rfd;
   assign bus.o_os_data = os_data;
   assign bus.o_os_dv   = os_dv;

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         for (int k = 0; k < N_TAPS; k++) begin
            taps[k]   <= '0;
            coeffs[k] <= '0;
         end
         pend_wr   <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         os_data   <= '0;
         os_dv     <= 1'b0;
         is_rfd    <= 1'b1;
      end else if (i_en) begin
         case (state)
            IDLE: begin
               // A write landing with an accept is parked until the sample completes.
               if (bus.i_coeff_wr && addr_ok) begin
                  if (bus.i_is_dv) begin
                     pend_wr   <= 1'b1;
                     pend_addr <= bus.i_coeff_addr;
                     pend_data <= bus.i_coeff_data;
                  end else begin
                     coeffs[bus.i_coeff_addr] <= bus.i_coeff_data;
                  end
               end
               if (bus.i_is_dv) begin
                  taps[0] <= bus.i_is_data;
                  for (int k = 1; k < N_TAPS; k++) taps[k] <= taps[k-1];
                  acc    <= '0;
                  cnt    <= '0;
                  is_rfd <= 1'b0;
                  state  <= MAC;
               end
            end
            MAC: begin
               acc <= sum;
               cnt <= cnt + 1'b1;
               if (cnt == LAST_TAP) begin
                  os_data <= saturate(round_half(sum));
                  os_dv   <= 1'b1;
                  state   <= OUT;
               end
            end
            OUT: begin
               if (bus.i_os_rfd) begin
                  os_dv  <= 1'b0;
                  is_rfd <= 1'b1;
                  state  <= IDLE;
                  if (pend_wr) begin
                     coeffs[pend_addr] <= pend_data;
                     pend_wr           <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fir_filter_tdm.sv
// Directed plus randomized bench for fir_filter_tdm with a sum-of-products reference model.
module tb_fir_filter_tdm;
   localparam int N_TAPS = 4;
   localparam int WI = 8;
   localparam int WC = 8;
   localparam int WO = 8;
   localparam int SHIFT = WI + WC - WO;

   logic clk = 1'b0;
   logic rst;
   logic en;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   mcoef [N_TAPS];
   int   mhist [N_TAPS];
   int   last_out;

   fir_filter_tdm_if #(.N_TAPS(N_TAPS), .WW_INPUT(WI), .WW_COEFF(WC), .WW_OUTPUT(WO)) bus ();

   fir_filter_tdm #(.N_TAPS(N_TAPS), .WW_INPUT(WI), .WW_COEFF(WC), .WW_OUTPUT(WO)) dut (
      .clk   (clk),
      .i_rst (rst),
      .i_en  (en),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: y = sum c[k]*x[n-k], optional half-LSB, floor-divide, clamp to output range.
   function automatic int model_out();
      int s = 0;
      for (int k = 0; k < N_TAPS; k++) s += mhist[k] * mcoef[k];
`ifdef FIR_ROUND_EN
      s += 1 << (SHIFT - 1);
`endif
      s = s >>> SHIFT;
      if (s > (1 << (WO - 1)) - 1) s = (1 << (WO - 1)) - 1;
      if (s < -(1 << (WO - 1)))    s = -(1 << (WO - 1));
      return s;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N_TAPS; k++) begin
         mcoef[k] = 0;
         mhist[k] = 0;
      end
   endtask

   task automatic write_coeff(input int a, input logic signed [7:0] d);
      bus.i_coeff_wr   = 1'b1;
      bus.i_coeff_addr = 2'(a);
      bus.i_coeff_data = d;
      tick();
      bus.i_coeff_wr   = 1'b0;
      mcoef[a] = int'(d);
   endtask

   task automatic do_sample(input logic signed [7:0] x, input int stall_at, input int stall_len,
                            input int bp_len, input bit mac_wr, input bit acc_wr,
                            input logic signed [7:0] acc_wr_data);
      int exp_v;
      int cyc;
      check("rfd_idle", bus.o_is_rfd, 1);
      bus.i_os_rfd  = (bp_len == 0);
      bus.i_is_dv   = 1'b1;
      bus.i_is_data = x;
      if (acc_wr) begin
         bus.i_coeff_wr   = 1'b1;
         bus.i_coeff_addr = 2'd0;
         bus.i_coeff_data = acc_wr_data;
      end
      tick();
      bus.i_is_dv    = 1'b0;
      bus.i_coeff_wr = 1'b0;
      for (int k = N_TAPS - 1; k > 0; k--) mhist[k] = mhist[k-1];
      mhist[0] = int'(x);
      exp_v = model_out();
      if (acc_wr) mcoef[0] = int'(acc_wr_data);
      cyc = 0;
      while (bus.o_os_dv !== 1'b1 && cyc < 40) begin
         if (cyc == stall_at) begin
            en = 1'b0;
            repeat (stall_len) begin
               tick();
               check("stall_rfd", bus.o_is_rfd, 0);
               check("stall_dv", bus.o_os_dv, 0);
            end
            en = 1'b1;
         end
         if (mac_wr && cyc == 1) begin
            bus.i_coeff_wr   = 1'b1;
            bus.i_coeff_addr = 2'd1;
            bus.i_coeff_data = 8'sh7f;
         end
         tick();
         bus.i_coeff_wr = 1'b0;
         cyc++;
      end
      check("latency", cyc, N_TAPS);
      check("out_data", bus.o_os_data, exp_v);
      last_out = int'(bus.o_os_data);
      repeat (bp_len) begin
         tick();
         check("bp_dv", bus.o_os_dv, 1);
         check("bp_data", bus.o_os_data, exp_v);
         check("bp_rfd", bus.o_is_rfd, 0);
      end
      bus.i_os_rfd = 1'b1;
      tick();
      check("ret_dv", bus.o_os_dv, 0);
      check("ret_rfd", bus.o_is_rfd, 1);
   endtask

   initial begin
      logic signed [7:0] imp_c [4];
      logic signed [7:0] rx;
      int exp_lit [5];
      imp_c = '{8'sh80, 8'sh40, 8'she0, 8'sh10};
      exp_lit = '{-32, 16, -8, 4, 0};
      rst = 1'b1;
      en  = 1'b1;
      bus.i_is_data = '0;
      bus.i_is_dv = 1'b0;
      bus.i_os_rfd = 1'b1;
      bus.i_coeff_wr = 1'b0;
      bus.i_coeff_addr = '0;
      bus.i_coeff_data = '0;
      model_reset();
      tick();
      tick();
      check("rst_data", bus.o_os_data, 0);
      check("rst_dv", bus.o_os_dv, 0);
      check("rst_rfd", bus.o_is_rfd, 1);
      rst = 1'b0;
      tick();

      // Impulse response
      for (int k = 0; k < 4; k++) write_coeff(k, imp_c[k]);
      do_sample(8'sh40, -1, 0, 0, 0, 0, 0);
      check("imp_0", last_out, exp_lit[0]);
      for (int k = 1; k < 5; k++) begin
         do_sample(8'sh00, -1, 0, 0, 0, 0, 0);
         check("imp_n", last_out, exp_lit[k]);
      end

      // Backpressure in OUT, then enable stall during MAC
      do_sample(8'sh40, -1, 0, 10, 0, 0, 0);
      check("bp_imp0", last_out, -32);
      do_sample(8'sh00, 2, 5, 0, 0, 0, 0);
      check("stall_imp1", last_out, 16);

      // Saturation
      for (int k = 0; k < 4; k++) write_coeff(k, 8'sh80);
      for (int k = 0; k < 4; k++) do_sample(8'sh80, -1, 0, 0, 0, 0, 0);
      check("sat_pos", last_out, 127);

      // Write gating: mid-MAC write ignored, same-edge write deferred to next sample
      for (int k = 0; k < 4; k++) write_coeff(k, imp_c[k]);
      do_sample(8'sh40, -1, 0, 0, 1, 0, 0);
      do_sample(8'sh10, -1, 0, 0, 0, 1, 8'sh20);
      do_sample(8'sh10, -1, 0, 0, 0, 0, 0);
      // Address 7 does not fit the 2-bit index at N_TAPS=4, so no out-of-range write exists here.

      // Randomized traffic
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 2) == 0) write_coeff(int'($urandom_range(0, 3)), 8'($urandom));
         rx = 8'($urandom);
         do_sample(rx, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
                   int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 8'($urandom));
      end

      // Rounding
      write_coeff(0, 8'sh02);
      for (int k = 1; k < 4; k++) write_coeff(k, 8'sh00);
      do_sample(8'sh7f, -1, 0, 0, 0, 0, 0);
`ifdef FIR_ROUND_EN
      check("round", last_out, 1);
`else
      check("trunc", last_out, 0);
`endif

      // Asynchronous reset in the middle of MAC
      for (int k = 0; k < 4; k++) write_coeff(k, imp_c[k]);
      do_sample(8'sh40, -1, 0, 0, 0, 0, 0);
      bus.i_is_dv = 1'b1;
      bus.i_is_data = 8'sh55;
      tick();
      bus.i_is_dv = 1'b0;
      tick();
      #2 rst = 1'b1;
      #1;
      check("arst_data", bus.o_os_data, 0);
      check("arst_dv", bus.o_os_dv, 0);
      check("arst_rfd", bus.o_is_rfd, 1);
      tick();
      rst = 1'b0;
      model_reset();
      tick();
      do_sample(8'sh40, -1, 0, 0, 0, 0, 0);
      check("arst_imp0", last_out, 0);
      do_sample(8'sh7f, -1, 0, 0, 0, 0, 0);
      check("arst_imp1", last_out, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
